// File: rtl/bus_mem_responder.sv
// bus_mem_responder: single-word memory responder for a request/ready bus.
// Serves one read or write per transaction after WAIT_CYCLES wait states and
// raises sticky Done/Fail flags from committed writes so a self-checking
// program can end the run. The array is never cleared by reset; its contents
// are whatever was last written through the bus.
module bus_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] DONE_ADR    = 32'd100,
  parameter logic [31:0] DONE_DATA   = 32'd7,
  parameter logic [31:0] SCRATCH_ADR = 32'd96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        BusErr,
  output logic        Done,
  output logic        Fail
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);
  localparam logic [31:0] ADR_LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [31:0] BAD_READ  = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_c;

  logic [31:0] adr_q;
  logic [31:0] wdata_q;
  logic        write_q;

  logic [31:0] rsp_adr_c;
  logic        rsp_write_c;
  logic        rsp_in_range_c;
  logic        commit_c;
  logic        commit_in_range_c;

  logic [31:0] mem [DEPTH_WORDS];

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, count down wait states, one RESP cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MemReq) begin
          accept_c = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request capture; later changes on the inputs are ignored until IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      adr_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else if (accept_c) begin
      adr_q   <= Adr;
      wdata_q <= WriteData;
      write_q <= MemWrite;
    end
  end

  // Response source: with zero wait states RESP is entered straight from IDLE,
  // before the latched copy exists, so the live request is used then
  always_comb begin
    rsp_adr_c         = (state_q == ST_IDLE) ? Adr : adr_q;
    rsp_write_c       = (state_q == ST_IDLE) ? MemWrite : write_q;
    rsp_in_range_c    = (rsp_adr_c < ADR_LIMIT);
    commit_c          = (state_q == ST_RESP) && write_q;
    commit_in_range_c = (adr_q < ADR_LIMIT);
  end

  // Registered response strobes, read data and sticky completion flags
  always_ff @(posedge clk) begin
    if (reset) begin
      MemReady <= 1'b0;
      BusErr   <= 1'b0;
      ReadData <= '0;
      Done     <= 1'b0;
      Fail     <= 1'b0;
    end else begin
      MemReady <= (state_d == ST_RESP);
      BusErr   <= (state_d == ST_RESP) && !rsp_in_range_c;
      if ((state_d == ST_RESP) && !rsp_write_c) begin
        ReadData <= rsp_in_range_c ? mem[rsp_adr_c[IDX_W+1:2]] : BAD_READ;
      end
      if (commit_c) begin
        if (adr_q == DONE_ADR) begin
          if (wdata_q == DONE_DATA) begin
            Done <= 1'b1;
          end else begin
            Fail <= 1'b1;
          end
        end else if (adr_q != SCRATCH_ADR) begin
          Fail <= 1'b1;
        end
      end
    end
  end

  // Word store commits on the edge leaving RESP; a reset there drops it
  always_ff @(posedge clk) begin
    if (!reset && commit_c && commit_in_range_c) begin
      mem[adr_q[IDX_W+1:2]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: one instance with zero wait states, one with
// two. Directed vector table, reset/no-lockout sequences, then random traffic
// against an array model of memory and flags.
module tb_bus_mem_responder;

  localparam int unsigned DEPTH   = 64;
  localparam logic [31:0] BYTES   = 32'(DEPTH * 4);
  localparam int          MAXWAIT = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic        req  [2];
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic        we   [2];
  wire  [31:0] rdata [2];
  wire         rdy  [2];
  wire         berr [2];
  wire         done [2];
  wire         fail [2];

  bus_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst[0]), .MemReq(req[0]), .Adr(adr[0]),
    .WriteData(wdat[0]), .MemWrite(we[0]), .ReadData(rdata[0]),
    .MemReady(rdy[0]), .BusErr(berr[0]), .Done(done[0]), .Fail(fail[0])
  );

  bus_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .reset(rst[1]), .MemReq(req[1]), .Adr(adr[1]),
    .WriteData(wdat[1]), .MemWrite(we[1]), .ReadData(rdata[1]),
    .MemReady(rdy[1]), .BusErr(berr[1]), .Done(done[1]), .Fail(fail[1])
  );

  int total = 0;
  int bad   = 0;

  // Reference model: memory words with written-ness, sticky flags
  logic [31:0] mmem  [2][DEPTH];
  bit          mval  [2][DEPTH];
  bit          mdone [2];
  bit          mfail [2];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] rd;
    logic        be;
    logic        dn;
    logic        fl;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
    end
  endtask

  function automatic int exp_lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic void model_write(input int d, input logic [31:0] a,
                                      input logic [31:0] wd);
    if (a < BYTES) begin
      mmem[d][int'(a >> 2)] = wd;
      mval[d][int'(a >> 2)] = 1'b1;
    end
    if (a == 32'd100) begin
      if (wd == 32'd7) mdone[d] = 1'b1;
      else             mfail[d] = 1'b1;
    end else if (a != 32'd96) begin
      mfail[d] = 1'b1;
    end
  endfunction

  // One full transaction; scrambles the bus while waiting to prove latching
  task automatic txn(input int d, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd,
                     output logic be, output int lat, output logic dn,
                     output logic fl, output logic clean);
    bit got;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = wd;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < MAXWAIT) begin
      @(negedge clk);
      lat++;
      if (rdy[d] === 1'b1) begin
        got = 1'b1;
      end else begin
        adr[d] = $urandom; wdat[d] = $urandom; we[d] = 1'($urandom);
      end
    end
    rd = rdata[d];
    be = berr[d];
    req[d] = 1'b0;
    @(negedge clk);
    dn = done[d];
    fl = fail[d];
    clean = (rdy[d] === 1'b0) && (berr[d] === 1'b0);
  endtask

  task automatic do_reset(input int d, input int n);
    @(negedge clk);
    rst[d] = 1'b1;
    req[d] = 1'b0;
    repeat (n) @(negedge clk);
    rst[d] = 1'b0;
    mdone[d] = 1'b0;
    mfail[d] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a, wd, e_rd;
    logic        be, dn, fl, clean, w, oor, seen;
    int          lat, d, sel;

    vecs[0] = '{1'b0, 32'd0,     32'd0,          1'b1, 32'hE04F_000F, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'd96,    32'd5,          1'b0, 32'd0,         1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'd96,    32'd0,          1'b1, 32'd5,         1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'd100,   32'd7,          1'b0, 32'd0,         1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'd8,     32'h1234_5678,  1'b0, 32'd0,         1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 32'd8,     32'd0,          1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 32'h400,   32'd0,          1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 32'h400,   32'hAAAA_5555,  1'b0, 32'd0,         1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 32'd0,     32'd0,          1'b1, 32'hE04F_000F, 1'b0, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 32'd6,     32'd0,          1'b1, 32'hCAFE_0004, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; wdat[i] = '0;
      mdone[i] = 1'b0; mfail[i] = 1'b0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        mmem[i][k] = '0;
        mval[i][k] = 1'b0;
      end
    end

    // Reset held for three edges
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("reset MemReady", i, 32'(rdy[i]), 32'd0);
      chk("reset BusErr", i, 32'(berr[i]), 32'd0);
      chk("reset Done", i, 32'(done[i]), 32'd0);
      chk("reset Fail", i, 32'(fail[i]), 32'd0);
      chk("reset ReadData", i, rdata[i], 32'd0);
    end

    // Preload through the bus, then clear the flags that preload raised
    for (int i = 0; i < 2; i++) begin
      txn(i, 1'b1, 32'd0, 32'hE04F_000F, rd, be, lat, dn, fl, clean);
      model_write(i, 32'd0, 32'hE04F_000F);
      txn(i, 1'b1, 32'd4, 32'hCAFE_0004, rd, be, lat, dn, fl, clean);
      model_write(i, 32'd4, 32'hCAFE_0004);
      txn(i, 1'b1, 32'd8, 32'h1111_1111, rd, be, lat, dn, fl, clean);
      model_write(i, 32'd8, 32'h1111_1111);
      do_reset(i, 3);
    end

    // Directed vector table on both wait-state settings
    for (int i = 0; i < 2; i++) begin
      for (int v = 0; v < 10; v++) begin
        txn(i, vecs[v].w, vecs[v].a, vecs[v].wd, rd, be, lat, dn, fl, clean);
        chk($sformatf("vec%0d latency", v), i, 32'(lat), 32'(exp_lat(i)));
        if (vecs[v].chk_rd) chk($sformatf("vec%0d ReadData", v), i, rd, vecs[v].rd);
        chk($sformatf("vec%0d BusErr", v), i, 32'(be), 32'(vecs[v].be));
        chk($sformatf("vec%0d Done", v), i, 32'(dn), 32'(vecs[v].dn));
        chk($sformatf("vec%0d Fail", v), i, 32'(fl), 32'(vecs[v].fl));
        chk($sformatf("vec%0d one-cycle strobe", v), i, 32'(clean), 32'd1);
        if (vecs[v].w) model_write(i, vecs[v].a, vecs[v].wd);
      end
    end

    // Reset while in WAIT: write to 4 must vanish, no strobe
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'd4; wdat[1] = 32'h0BAD_0BAD;
    @(posedge clk);
    @(negedge clk);
    seen = (rdy[1] === 1'b1) || (berr[1] === 1'b1);
    rst[1] = 1'b1;
    req[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst[1] = 1'b0;
      if (rdy[1] === 1'b1 || berr[1] === 1'b1) seen = 1'b1;
    end
    mdone[1] = 1'b0;
    mfail[1] = 1'b0;
    chk("reset in WAIT strobe", 1, 32'(seen), 32'd0);
    chk("reset in WAIT Done", 1, 32'(done[1]), 32'd0);
    chk("reset in WAIT Fail", 1, 32'(fail[1]), 32'd0);
    txn(1, 1'b0, 32'd4, 32'd0, rd, be, lat, dn, fl, clean);
    chk("read after WAIT reset", 1, rd, 32'hCAFE_0004);
    chk("flags after WAIT reset", 1, {30'd0, dn, fl}, 32'd0);

    // Reset while in RESP: write to 8 dropped, no flag set
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'd8; wdat[1] = 32'h7777_7777;
    @(posedge clk);
    lat = 0;
    while (rdy[1] !== 1'b1 && lat < MAXWAIT) begin
      @(negedge clk);
      lat++;
    end
    chk("RESP-reset latency", 1, 32'(lat), 32'd3);
    rst[1] = 1'b1;
    req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    @(negedge clk);
    chk("reset in RESP Fail", 1, 32'(fail[1]), 32'd0);
    chk("reset in RESP Done", 1, 32'(done[1]), 32'd0);
    txn(1, 1'b0, 32'd8, 32'd0, rd, be, lat, dn, fl, clean);
    chk("read after RESP reset", 1, rd, 32'h1234_5678);

    // MemReq left high after MemReady: one idle cycle, then a new transaction
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'd0;
    @(posedge clk);
    lat = 0;
    while (rdy[1] !== 1'b1 && lat < MAXWAIT) begin
      @(negedge clk);
      lat++;
    end
    chk("back-to-back first latency", 1, 32'(lat), 32'd3);
    @(negedge clk);
    chk("back-to-back idle gap", 1, 32'(rdy[1]), 32'd0);
    @(posedge clk);
    lat = 0;
    while (rdy[1] !== 1'b1 && lat < MAXWAIT) begin
      @(negedge clk);
      req[1] = 1'b0;
      lat++;
    end
    chk("back-to-back second latency", 1, 32'(lat), 32'd3);
    chk("back-to-back ReadData", 1, rdata[1], 32'hE04F_000F);
    req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("back-to-back settles", 1, 32'(rdy[1]), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 160; n++) begin
      d = n % 2;
      if ($urandom_range(0, 15) == 0) begin
        do_reset(d, 2);
        @(negedge clk);
        chk("random reset flags", d, {30'd0, done[d], fail[d]}, 32'd0);
      end
      sel = int'($urandom_range(0, 7));
      case (sel)
        4:       a = 32'd96;
        5:       a = 32'd100;
        6:       a = 32'($urandom_range(256, 4095));
        7:       a = $urandom;
        default: a = 32'($urandom_range(0, 255));
      endcase
      w  = 1'($urandom);
      wd = (sel == 5 && $urandom_range(0, 1) == 0) ? 32'd7 : $urandom;
      oor = (a >= BYTES);
      e_rd = oor ? 32'hDEAD_BEEF : mmem[d][int'(a >> 2)];
      txn(d, w, a, wd, rd, be, lat, dn, fl, clean);
      chk("random latency", d, 32'(lat), 32'(exp_lat(d)));
      chk("random BusErr", d, 32'(be), 32'(oor));
      if (!w && (oor || mval[d][int'(a >> 2) % int'(DEPTH)]))
        chk("random ReadData", d, rd, e_rd);
      if (w) model_write(d, a, wd);
      chk("random Done", d, 32'(dn), 32'(mdone[d]));
      chk("random Fail", d, 32'(fl), 32'(mfail[d]));
      chk("random strobe width", d, 32'(clean), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
